// File: rtl/i2c_target_responder_pkg.sv
// Shared types and constants for the I2C target responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_target_responder_pkg;

    localparam int unsigned I2C_BYTE_W = 8;
    localparam logic        I2C_ACK    = 1'b0;
    localparam logic        I2C_NACK   = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_LOAD,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } tgt_state_e;

    // One-cycle bus events derived from the filtered SCL/SDA lines.
    typedef struct packed {
        logic start;
        logic stop;
        logic scl_rise;
        logic scl_fall;
    } bus_evt_t;

endpackage

// File: rtl/i2c_target_responder_line_filter.sv
// Synchronizes one bus line, rejects pulses shorter than FILTER_LEN clks, flags edges.
// Latency: 2 sync clks + FILTER_LEN clks to level_o; rise/fall pulse with the new level.
// Backpressure: none; free-running on every clk.
module i2c_line_filter #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       sync_q, sync_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Accept a new level only after it has differed from the current one for FILTER_LEN clks.
    always_comb begin
        sync_d  = {sync_q[0], line_i};
        level_d = level_q;
        prev_d  = level_q;
        cnt_d   = '0;
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Lines idle high, so every stage resets to 1 to avoid a false edge out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 2'b11;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = level_q & ~prev_q;
    assign fall_o  = ~level_q & prev_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: ACKs TARGET_ADDR, streams written bytes out and read bytes in.
// Latency: bus action 1 clk after the filtered edge (filter adds 2 + FILTER_LEN clks).
// Backpressure: stretches SCL while rd_valid_i is low (STRETCH_EN=1), else sends 8'hFF.
module i2c_target_responder
    import i2c_target_responder_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR = 7'h22,
    parameter int unsigned FILTER_LEN  = 3,
    parameter bit          STRETCH_EN  = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       scl_drive_low_o,
    output logic       sda_drive_low_o,
    output logic       xfer_start_o,
    output logic       xfer_rw_o,
    output logic       xfer_stop_o,
    output logic [7:0] wr_data_o,
    output logic       wr_valid_o,
    input  logic [7:0] rd_data_i,
    input  logic       rd_valid_i,
    output logic       rd_ready_o,
    output logic       rd_nack_o
);

    localparam logic [3:0] BYTE_CNT = 4'(I2C_BYTE_W);
    localparam logic [3:0] LAST_BIT = BYTE_CNT - 4'd1;

    logic     scl_lvl, scl_rise, scl_fall;
    logic     sda_lvl, sda_rise, sda_fall;
    bus_evt_t evt;

    tgt_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       sda_low_q, sda_low_d;
    logic       scl_low_q, scl_low_d;
    logic       rw_q, rw_d;
    logic       matched_q, matched_d;
    logic       start_q, start_d;
    logic       stop_q, stop_d;
    logic       wr_vld_q, wr_vld_d;
    logic       rd_rdy_q, rd_rdy_d;
    logic       rd_nack_q, rd_nack_d;

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (scl_i),
        .level_o(scl_lvl),
        .rise_o (scl_rise),
        .fall_o (scl_fall)
    );

    i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .line_i (sda_i),
        .level_o(sda_lvl),
        .rise_o (sda_rise),
        .fall_o (sda_fall)
    );

    assign evt = '{start: sda_fall & scl_lvl, stop: sda_rise & scl_lvl,
                   scl_rise: scl_rise, scl_fall: scl_fall};

    // Protocol FSM: START/STOP override everything, then per-state bit handling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        wr_data_d = wr_data_q;
        sda_low_d = sda_low_q;
        scl_low_d = 1'b0;
        rw_d      = rw_q;
        matched_d = matched_q;
        start_d   = 1'b0;
        stop_d    = 1'b0;
        wr_vld_d  = 1'b0;
        rd_rdy_d  = 1'b0;
        rd_nack_d = 1'b0;
        if (evt.start) begin
            state_d   = ST_ADDR;
            cnt_d     = '0;
            sda_low_d = 1'b0;
            matched_d = 1'b0;
        end else if (evt.stop) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            sda_low_d = 1'b0;
            stop_d    = matched_q;
            matched_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_ADDR: begin
                    if (evt.scl_rise && cnt_q < BYTE_CNT) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (evt.scl_fall && cnt_q == BYTE_CNT) begin
                        cnt_d = '0;
                        if (shift_q[7:1] == TARGET_ADDR) begin
                            sda_low_d = 1'b1;
                            rw_d      = shift_q[0];
                            start_d   = 1'b1;
                            matched_d = 1'b1;
                            state_d   = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (evt.scl_fall) begin
                        sda_low_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = rw_q ? ST_RD_LOAD : ST_WR_DATA;
                    end
                end
                ST_WR_DATA: begin
                    if (evt.scl_rise && cnt_q < BYTE_CNT) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            wr_data_d = {shift_q[6:0], sda_lvl};
                            wr_vld_d  = 1'b1;
                        end
                    end else if (evt.scl_fall && cnt_q == BYTE_CNT) begin
                        sda_low_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_WR_ACK;
                    end
                end
                ST_WR_ACK: begin
                    if (evt.scl_fall) begin
                        sda_low_d = 1'b0;
                        state_d   = ST_WR_DATA;
                    end
                end
                ST_RD_LOAD: begin
                    // Keep any stretch one more clk so bit7 settles before SCL is let go.
                    if (rd_valid_i) begin
                        shift_d   = rd_data_i;
                        sda_low_d = ~rd_data_i[7];
                        rd_rdy_d  = 1'b1;
                        scl_low_d = scl_low_q;
                        cnt_d     = '0;
                        state_d   = ST_RD_DATA;
                    end else if (STRETCH_EN) begin
                        scl_low_d = 1'b1;
                    end else begin
                        shift_d   = 8'hFF;
                        sda_low_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (evt.scl_fall) begin
                        if (cnt_q == LAST_BIT) begin
                            sda_low_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_low_d = ~shift_q[6];
                            cnt_d     = cnt_q + 4'd1;
                        end
                    end
                end
                ST_RD_ACK: begin
                    if (evt.scl_rise && sda_lvl == I2C_NACK) begin
                        rd_nack_d = 1'b1;
                        state_d   = ST_IGNORE;
                    end else if (evt.scl_fall) begin
                        state_d = ST_RD_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // State and output registers; reset releases both bus lines at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            wr_data_q <= '0;
            sda_low_q <= 1'b0;
            scl_low_q <= 1'b0;
            rw_q      <= 1'b0;
            matched_q <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            rd_rdy_q  <= 1'b0;
            rd_nack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            wr_data_q <= wr_data_d;
            sda_low_q <= sda_low_d;
            scl_low_q <= scl_low_d;
            rw_q      <= rw_d;
            matched_q <= matched_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
            wr_vld_q  <= wr_vld_d;
            rd_rdy_q  <= rd_rdy_d;
            rd_nack_q <= rd_nack_d;
        end
    end

    assign scl_drive_low_o = scl_low_q;
    assign sda_drive_low_o = sda_low_q;
    assign xfer_start_o    = start_q;
    assign xfer_rw_o       = rw_q;
    assign xfer_stop_o     = stop_q;
    assign wr_data_o       = wr_data_q;
    assign wr_valid_o      = wr_vld_q;
    assign rd_ready_o      = rd_rdy_q;
    assign rd_nack_o       = rd_nack_q;

endmodule

// File: tb/tb_i2c_target_responder.sv
// Directed bench: a bit-level I2C master drives the open-drain bus against the target.
// Latency: master half-phase is T clks, far longer than the target's filter delay.
// Backpressure: master waits on SCL high, so target stretching is honoured.
module tb_i2c_target_responder;
    import i2c_target_responder_pkg::*;

    localparam int T = 20;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       m_scl_low = 1'b0;
    logic       m_sda_low = 1'b0;
    logic       scl_i, sda_i;
    logic       scl_drive_low_o, sda_drive_low_o;
    logic       xfer_start_o, xfer_rw_o, xfer_stop_o;
    logic [7:0] wr_data_o;
    logic       wr_valid_o;
    logic [7:0] rd_data_i = 8'h00;
    logic       rd_valid_i = 1'b0;
    logic       rd_ready_o, rd_nack_o;

    int n_vec = 0;
    int n_miss = 0;
    int start_cnt = 0, stop_cnt = 0, rdy_cnt = 0, nack_cnt = 0, sda_drv_cnt = 0;
    logic last_rw = 1'b0;
    logic [7:0] wr_q[$];

    assign scl_i = ~(m_scl_low | scl_drive_low_o);
    assign sda_i = ~(m_sda_low | sda_drive_low_o);

    always #5 clk_i = ~clk_i;

    i2c_target_responder #(.TARGET_ADDR(7'h22), .FILTER_LEN(3), .STRETCH_EN(1'b1)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .scl_drive_low_o(scl_drive_low_o),
        .sda_drive_low_o(sda_drive_low_o),
        .xfer_start_o   (xfer_start_o),
        .xfer_rw_o      (xfer_rw_o),
        .xfer_stop_o    (xfer_stop_o),
        .wr_data_o      (wr_data_o),
        .wr_valid_o     (wr_valid_o),
        .rd_data_i      (rd_data_i),
        .rd_valid_i     (rd_valid_i),
        .rd_ready_o     (rd_ready_o),
        .rd_nack_o      (rd_nack_o)
    );

    // Pulse monitors, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (xfer_start_o) begin
            start_cnt++;
            last_rw = xfer_rw_o;
        end
        if (xfer_stop_o)     stop_cnt++;
        if (rd_ready_o)      rdy_cnt++;
        if (rd_nack_o)       nack_cnt++;
        if (sda_drive_low_o) sda_drv_cnt++;
        if (wr_valid_o)      wr_q.push_back(wr_data_o);
    end

    initial begin
        repeat (80000) @(posedge clk_i);
        $display("FAIL watchdog: run exceeded 80000 clks");
        $fatal(1);
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_scl_high();
        int waited = 0;
        while (scl_i !== 1'b1 && waited < 1000) begin
            @(posedge clk_i);
            #1;
            waited++;
        end
        if (scl_i !== 1'b1) check("scl_release_timeout", {31'b0, scl_i}, 32'd1);
    endtask

    task automatic m_start();
        m_sda_low = 1'b1; clks(T);
        m_scl_low = 1'b1; clks(T);
    endtask

    task automatic m_rstart();
        m_sda_low = 1'b0; clks(T);
        m_scl_low = 1'b0; wait_scl_high(); clks(T);
        m_sda_low = 1'b1; clks(T);
        m_scl_low = 1'b1; clks(T);
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; clks(T);
        m_scl_low = 1'b0; wait_scl_high(); clks(T);
        m_sda_low = 1'b0; clks(T);
    endtask

    task automatic m_write_bit(input logic b);
        m_sda_low = ~b; clks(T);
        m_scl_low = 1'b0; wait_scl_high(); clks(T);
        m_scl_low = 1'b1; clks(T);
    endtask

    task automatic m_read_bit(output logic b);
        m_sda_low = 1'b0; clks(T);
        m_scl_low = 1'b0; wait_scl_high(); clks(T / 2);
        b = sda_i; clks(T / 2);
        m_scl_low = 1'b1; clks(T);
    endtask

    task automatic m_write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) m_write_bit(b[i]);
        m_read_bit(ack);
    endtask

    task automatic m_read_byte(output logic [7:0] d, input logic nack);
        logic bit_v;
        for (int i = 7; i >= 0; i--) begin
            m_read_bit(bit_v);
            d[i] = bit_v;
        end
        m_write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic       bit_v;
        logic [7:0] d;
        int         s0, p0, r0, n0, drv0, held, seen;

        // Reset state.
        #1;
        check("reset_outputs", {15'b0, scl_drive_low_o, sda_drive_low_o, xfer_start_o, xfer_rw_o,
              xfer_stop_o, wr_valid_o, rd_ready_o, rd_nack_o, wr_data_o}, 32'd0);
        clks(3);
        rst_ni = 1'b1;
        clks(10);
        check("reset_state", {28'b0, dut.state_q}, {28'b0, ST_IDLE});

        // Write 0x05, 0xA5 to 0x22.
        s0 = start_cnt; p0 = stop_cnt;
        m_start();
        m_write_byte(8'h44, ack); check("wr_addr_ack", {31'b0, ack}, 32'd0);
        check("wr_start_pulse", start_cnt, s0 + 1);
        check("wr_rw", {31'b0, last_rw}, 32'd0);
        m_write_byte(8'h05, ack); check("wr_b0_ack", {31'b0, ack}, 32'd0);
        m_write_byte(8'hA5, ack); check("wr_b1_ack", {31'b0, ack}, 32'd0);
        m_stop();
        clks(10);
        check("wr_count", wr_q.size(), 2);
        if (wr_q.size() == 2) begin
            check("wr_byte0", {24'b0, wr_q[0]}, 32'h05);
            check("wr_byte1", {24'b0, wr_q[1]}, 32'hA5);
        end
        check("wr_stop_pulse", stop_cnt, p0 + 1);
        wr_q.delete();

        // Write to non-matching 0x23: target stays off the bus.
        s0 = start_cnt; p0 = stop_cnt; drv0 = sda_drv_cnt;
        m_start();
        m_write_byte(8'h46, ack); check("miss_addr_nack", {31'b0, ack}, 32'd1);
        m_write_byte(8'h77, ack); check("miss_data_nack", {31'b0, ack}, 32'd1);
        m_stop();
        clks(10);
        check("miss_no_drive", sda_drv_cnt, drv0);
        check("miss_no_start", start_cnt, s0);
        check("miss_no_stop", stop_cnt, p0);
        check("miss_no_data", wr_q.size(), 0);

        // Write 0x11, repeated START, read one byte with NACK.
        s0 = start_cnt; p0 = stop_cnt;
        m_start();
        m_write_byte(8'h44, ack); check("rs_addr_ack", {31'b0, ack}, 32'd0);
        m_write_byte(8'h11, ack); check("rs_data_ack", {31'b0, ack}, 32'd0);
        rd_data_i = 8'h5A; rd_valid_i = 1'b1;
        m_rstart();
        m_write_byte(8'h45, ack); check("rs_raddr_ack", {31'b0, ack}, 32'd0);
        check("rs_two_starts", start_cnt, s0 + 2);
        check("rs_rw_read", {31'b0, last_rw}, 32'd1);
        check("rs_no_stop_between", stop_cnt, p0);
        m_read_byte(d, 1'b1);
        check("rs_read_byte", {24'b0, d}, 32'h5A);
        m_stop();
        rd_valid_i = 1'b0;
        clks(10);
        check("rs_wr_byte", {24'b0, (wr_q.size() > 0) ? wr_q[0] : 8'hXX}, 32'h11);
        check("rs_stop_pulse", stop_cnt, p0 + 1);
        wr_q.delete();

        // Read 0x3C (ACK) then 0xC3 (NACK).
        p0 = stop_cnt; r0 = rdy_cnt; n0 = nack_cnt;
        rd_data_i = 8'h3C; rd_valid_i = 1'b1;
        m_start();
        m_write_byte(8'h45, ack); check("rd_addr_ack", {31'b0, ack}, 32'd0);
        check("rd_first_pop", rdy_cnt, r0 + 1);
        rd_data_i = 8'hC3;
        m_read_byte(d, 1'b0); check("rd_byte0", {24'b0, d}, 32'h3C);
        m_read_byte(d, 1'b1); check("rd_byte1", {24'b0, d}, 32'hC3);
        check("rd_two_pops", rdy_cnt, r0 + 2);
        check("rd_nack_pulse", nack_cnt, n0 + 1);
        m_stop();
        rd_valid_i = 1'b0;
        clks(10);
        check("rd_stop_pulse", stop_cnt, p0 + 1);

        // Read with late data: SCL stretched until the byte is loaded.
        m_start();
        m_write_byte(8'h45, ack); check("st_addr_ack", {31'b0, ack}, 32'd0);
        check("st_stretch_on", {31'b0, scl_drive_low_o}, 32'd1);
        fork
            m_read_byte(d, 1'b1);
            begin
                held = 0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk_i);
                    if (scl_drive_low_o) held++;
                end
                check("st_held_50", held, 50);
                rd_data_i = 8'h96; rd_valid_i = 1'b1;
                seen = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk_i);
                    if (rd_ready_o) begin
                        seen = 1;
                        break;
                    end
                end
                check("st_pop_seen", seen, 1);
                check("st_scl_at_load", {31'b0, scl_drive_low_o}, 32'd1);
                rd_valid_i = 1'b0;
                @(negedge clk_i);
                check("st_scl_released", {31'b0, scl_drive_low_o}, 32'd0);
            end
        join
        check("st_read_byte", {24'b0, d}, 32'h96);
        m_stop();
        clks(10);

        // Short SDA glitches with SCL high are not START; a long low is.
        m_sda_low = 1'b1; clks(1); m_sda_low = 1'b0; clks(10);
        check("glitch1_idle", {28'b0, dut.state_q}, {28'b0, ST_IDLE});
        m_sda_low = 1'b1; clks(2); m_sda_low = 1'b0; clks(10);
        check("glitch2_idle", {28'b0, dut.state_q}, {28'b0, ST_IDLE});
        m_sda_low = 1'b1; clks(8);
        check("long_low_start", {28'b0, dut.state_q}, {28'b0, ST_ADDR});
        m_sda_low = 1'b0; clks(10);
        check("long_low_stop", {28'b0, dut.state_q}, {28'b0, ST_IDLE});

        // Reset in the middle of a read byte.
        rd_data_i = 8'h00; rd_valid_i = 1'b1;
        m_start();
        m_write_byte(8'h45, ack); check("rst_addr_ack", {31'b0, ack}, 32'd0);
        for (int i = 0; i < 3; i++) m_read_bit(bit_v);
        check("rst_in_rd_data", {28'b0, dut.state_q}, {28'b0, ST_RD_DATA});
        check("rst_sda_driven", {31'b0, sda_drive_low_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("rst_drives_released", {30'b0, scl_drive_low_o, sda_drive_low_o}, 32'd0);
        clks(3);
        rst_ni = 1'b1;
        rd_valid_i = 1'b0;
        m_scl_low = 1'b0; clks(T);
        m_sda_low = 1'b0; clks(T);
        check("rst_state_idle", {28'b0, dut.state_q}, {28'b0, ST_IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- Synthesizable I2C target (slave) that answers the transactions issued by the IICMB I2C master; the other end of the same I2C bus.
- Sits in the bench top beside the DUT on the open-drain SCL/SDA wires. It replaces the behavioural responder when running emulation/FPGA builds.
- Bridges bus bytes to a simple byte-stream interface: a write stream out and a read stream in, with clock stretching when read data is late.

Parameters:
- TARGET_ADDR, 7'h22, 7-bit address this target ACKs.
- FILTER_LEN, 3, clk cycles an input level must be stable before it is accepted (glitch filter).
- STRETCH_EN, 1, 1 = hold SCL low while waiting for rd_valid_i; 0 = send 8'hFF instead when data is absent.

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- scl_i  in  1  bus SCL level
- sda_i  in  1  bus SDA level
- scl_drive_low_o  out  1  1 = pull SCL low (stretch)
- sda_drive_low_o  out  1  1 = pull SDA low (ACK / data 0)
- xfer_start_o  out  1  pulse: address matched; xfer_rw_o valid
- xfer_rw_o  out  1  1 = master read, 0 = master write; held until next start
- xfer_stop_o  out  1  pulse: STOP seen after a matched transfer
- wr_data_o  out  8  received byte
- wr_valid_o  out  1  1-cycle pulse with wr_data_o
- rd_data_i  in  8  byte to send to master
- rd_valid_i  in  1  rd_data_i available
- rd_ready_o  out  1  1-cycle pop of rd_data_i
- rd_nack_o  out  1  pulse: master NACKed a read byte

Behaviour:
- Reset: all outputs 0; FSM to IDLE; bit counter 0. Reset mid-transfer releases SCL/SDA immediately.
- Input conditioning: 2-FF synchronizer, then FILTER_LEN stable-count filter per line. Edge detectors run on the filtered signals. Edge detect to action is 1 clk.
- START: filtered SDA falls while SCL high, from any state. FSM goes to ADDR, counter cleared, SDA released. A repeated START gives no xfer_stop_o.
- STOP: filtered SDA rises while SCL high. Go to IDLE. Pulse xfer_stop_o only if the address had matched.
- Sampling and driving: bits are sampled on SCL rising, MSB first. SDA/SCL drive outputs change only on SCL falling, except the stretch release.
- States:
  - IDLE: waits for START.
  - ADDR: shift 8 bits. On the 8th falling edge, if addr==TARGET_ADDR, assert sda_drive_low_o, latch R/W, pulse xfer_start_o, go to ADDR_ACK; else go to IGNORE.
  - ADDR_ACK: on the next SCL falling, release SDA. Write goes to WR_DATA. Read goes to RD_LOAD.
  - WR_DATA: shift 8 bits. On the 8th rising, pulse wr_valid_o with the byte. On the following falling, drive ACK and go to WR_ACK.
  - WR_ACK: on the next falling, release SDA and go to WR_DATA.
  - RD_LOAD: if rd_valid_i, pulse rd_ready_o, load the shifter and drive bit7 the same cycle. If not valid and STRETCH_EN, hold scl_drive_low_o. When rd_valid_i rises, load and drive bit7, then release SCL 1 clk later. If STRETCH_EN=0, load 8'hFF with no pop. Then go to RD_DATA.
  - RD_DATA: drive the next bit on each falling edge. After the 8th bit's falling edge, release SDA and go to RD_ACK.
  - RD_ACK: sample SDA on rising. 0 = ACK: on the falling edge go to RD_LOAD. 1 = NACK: pulse rd_nack_o, go to IGNORE.
  - IGNORE: no driving; only START or STOP exit.
- Never drives SDA while SCL is high, except holding an already-driven bit.
- The master asserting SDA=1 while the target drives 0 is not arbitration; the target ignores it.
- Simultaneous START and bit edge: START wins.

Decomposition:
- Shared package: state enum, I2C_BYTE_W=8, ACK/NACK bit constants, and a start/stop/bit event typedef.
- One sub-module, i2c_line_filter: synchronizer, glitch filter and edge detector. Instantiated twice, for SCL and SDA.

Test Plan:
- Master write to 0x22 with bytes 0x05 then 0xA5, then STOP:
  - 3 ACKs on the bus.
  - xfer_start_o with rw=0.
  - wr_valid_o pulses carrying 0x05 then 0xA5.
  - One xfer_stop_o.
- Write to 0x23: SDA never driven; no start, valid or stop pulses; next START to 0x22 is handled normally.
- Read from 0x22 with rd_valid_i=1 and data 0x3C then 0xC3; master ACKs byte 1 and NACKs byte 2:
  - Bus carries 0x3C, 0xC3.
  - 2 rd_ready_o pulses.
  - rd_nack_o after byte 2.
  - Then STOP gives xfer_stop_o.
- Read with rd_valid_i held low for 50 clks (STRETCH_EN=1):
  - SCL held low for those 50 clks.
  - Released 1 clk after data is loaded.
  - Byte is correct.
- Write 0x11, then repeated START and read:
  - Second xfer_start_o with rw=1.
  - No xfer_stop_o between the two transfers.
- 1-clk SDA glitch while SCL high (FILTER_LEN=3): no START/STOP detected.
- rst_ni asserted during RD_DATA: both drive outputs 0 that cycle; FSM in IDLE after reset.
